register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register width in bits; even, >= 4.
REQ-002 SHALL have parameter NREG, default 4, number of registers; >= 2, power of two.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = increment/decrement wrap, 1 = clamp.
REQ-004 SHALL have a single clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port E  input  NREG  per-register enable mask; any number of bits may be set.
REQ-008 SHALL have port FunSel  input  3  operation applied to every enabled register.
REQ-009 SHALL have port I  input  WIDTH  load data.
REQ-010 SHALL have port OutASel  input  log2(NREG)  read-port A register index.
REQ-011 SHALL have port OutBSel  input  log2(NREG)  read-port B register index.
REQ-012 SHALL have port OutA  output  WIDTH  contents of register OutASel.
REQ-013 SHALL have port OutB  output  WIDTH  contents of register OutBSel.
REQ-014 SHALL have port Wrap  output  NREG  per-register overflow/underflow flag, registered.

Function
REQ-015 SHALL apply FunSel to register k on a rising clk edge only when E[k]=1; otherwise register k holds.
REQ-016 SHALL decode FunSel as follows:
- 000: Q-1
- 001: Q+1
- 010: load I
- 011: clear
- 100: low half <= I low half, high half <= 0
- 101: high half <= I high half, low half kept
- 110: logical shift left by 1, LSB <= 0
- 111: hold
REQ-017 SHALL, with SATURATE=0, wrap increment at all-ones to 0 and decrement at 0 to all-ones.
REQ-018 SHALL, with SATURATE=1, clamp increment at all-ones and decrement at 0 (value unchanged).
REQ-019 SHALL set Wrap[k]=1 for exactly the one cycle after an edge at which register k was enabled and either wrapped/clamped on FunSel 000/001, or shifted out a 1 on 110; Wrap[k]=0 after all other edges.
REQ-020 SHALL drive OutA and OutB combinationally from current register state; both ports may select the same register.
REQ-021 SHALL update all enabled registers in the same edge; registers are independent, with no cross-register interaction.

Reset
REQ-022 SHALL, while rst=1, immediately force all registers and all Wrap bits to 0, regardless of clk.
REQ-023 SHALL let reset override any simultaneous E/FunSel activity; the first operation applied is at the first rising edge with rst=0.
REQ-024 SHALL cause OutA/OutB to read 0 during reset.

Configuration
REQ-025 SHALL compile in read-during-write bypass when macro REGISTER_BANK_BYPASS_EN is defined: if the selected register is enabled and FunSel is 010, the read port outputs I combinationally in that cycle.
REQ-026 SHALL, when REGISTER_BANK_BYPASS_EN is undefined, make read ports show stored contents only; a new value is visible the cycle after the edge.

Structure
REQ-027 SHALL place the FunSel encoding constants (FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LOADLO, FS_LOADHI, FS_SHL, FS_HOLD) in shared package register_bank_pkg.
REQ-028 SHALL implement one register as sub-module register_cell (WIDTH and SATURATE parameters; ports clk, rst, E, FunSel, I, Q, Wrap), instantiated NREG times with a generate loop.

Verification
REQ-029 SHALL cover: rst=1 mid-operation with E=1111, FunSel=001 -> all OutA/OutB and Wrap read 0 immediately, without waiting for a clk edge.
REQ-030 SHALL cover: WIDTH=16, SATURATE=0, R2=0xFFFF, E=0100, FunSel=001 -> R2=0x0000, Wrap=0100 for one cycle, then 0000.
REQ-031 SHALL cover: SATURATE=1, R1=0x0000, E=0010, FunSel=000 -> R1 stays 0x0000, Wrap[1]=1 for one cycle.
REQ-032 SHALL cover: R0=0xABCD, I=0x1234, E=0001, FunSel=101 -> R0=0x12CD; then FunSel=100 -> R0=0x0034.
REQ-033 SHALL cover: E=1010, FunSel=010, I=0x5A5A -> R1=R3=0x5A5A, while R0 and R2 are unchanged.
REQ-034 SHALL cover: with REGISTER_BANK_BYPASS_EN, OutASel=3, E=1000, FunSel=010, I=0x0F0F -> OutA=0x0F0F before the edge; without the macro, OutA shows the old value until after the edge.

Source files
------------

// File: rtl/register_bank_pkg.sv
// register_bank_pkg
//   Shared definitions for the register bank: the 3-bit FunSel operation
//   encoding used by the bank top and by each register cell.
//   No ports (package).
package register_bank_pkg;

  localparam int FUN_SEL_W = 3;

  localparam logic [FUN_SEL_W-1:0] FS_DEC    = 3'b000;  // Q-1
  localparam logic [FUN_SEL_W-1:0] FS_INC    = 3'b001;  // Q+1
  localparam logic [FUN_SEL_W-1:0] FS_LOAD   = 3'b010;  // load I
  localparam logic [FUN_SEL_W-1:0] FS_CLR    = 3'b011;  // clear
  localparam logic [FUN_SEL_W-1:0] FS_LOADLO = 3'b100;  // low half from I, high half zeroed
  localparam logic [FUN_SEL_W-1:0] FS_LOADHI = 3'b101;  // high half from I, low half kept
  localparam logic [FUN_SEL_W-1:0] FS_SHL    = 3'b110;  // shift left by one, LSB <= 0
  localparam logic [FUN_SEL_W-1:0] FS_HOLD   = 3'b111;  // hold

endpackage

// File: rtl/register_bank_if.sv
// register_bank_if
//   Bus bundle for the register bank.
//   Signals:
//     E       [NREG]        per-register enable mask
//     FunSel  [3]           operation applied to every enabled register
//     I       [WIDTH]       load data
//     OutASel [log2(NREG)]  read-port A index
//     OutBSel [log2(NREG)]  read-port B index
//     OutA    [WIDTH]       read-port A data
//     OutB    [WIDTH]       read-port B data
//     Wrap    [NREG]        registered overflow/underflow/shift-out flags
//   Protocol: no handshake. Control inputs are sampled on every rising clk
//   edge; E[k]=1 means "apply FunSel to register k at this edge". Read ports
//   are combinational and always valid.
//   Modports: master drives controls and reads data; slave is the bank.
interface register_bank_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4
);
  import register_bank_pkg::*;

  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [NREG-1:0]      E;
  logic [FUN_SEL_W-1:0] FunSel;
  logic [WIDTH-1:0]     I;
  logic [SEL_W-1:0]     OutASel;
  logic [SEL_W-1:0]     OutBSel;
  logic [WIDTH-1:0]     OutA;
  logic [WIDTH-1:0]     OutB;
  logic [NREG-1:0]      Wrap;

  modport master (
    output E, FunSel, I, OutASel, OutBSel,
    input  OutA, OutB, Wrap
  );

  modport slave (
    input  E, FunSel, I, OutASel, OutBSel,
    output OutA, OutB, Wrap
  );

endinterface

// File: rtl/register_bank_cell.sv
// register_cell
//   One register of the bank with its own operation decoder and wrap flag.
//   Parameters: WIDTH (even, >= 4), SATURATE (0 = wrap, 1 = clamp).
//   Ports:
//     clk     in   clock, state changes on rising edge
//     rst     in   asynchronous active-high reset
//     E       in   enable; register holds when 0
//     FunSel  in   operation select (see register_bank_pkg)
//     I       in   load data
//     Q       out  register contents
//     Wrap    out  1 for the cycle after an enabled edge that wrapped/clamped
//                  on inc/dec or shifted out a 1
module register_cell
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 E,
  input  logic [FUN_SEL_W-1:0] FunSel,
  input  logic [WIDTH-1:0]     I,
  output logic [WIDTH-1:0]     Q,
  output logic                 Wrap
);

  localparam int              HALF     = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_q;
  logic             next_wrap;

  always_comb begin
    next_q    = q_r;
    next_wrap = 1'b0;
    case (FunSel)
      FS_DEC: begin
        if (q_r == ZERO) begin
          next_wrap = 1'b1;
          next_q    = (SATURATE != 0) ? ZERO : ALL_ONES;
        end else begin
          next_q = q_r - ONE;
        end
      end
      FS_INC: begin
        if (q_r == ALL_ONES) begin
          next_wrap = 1'b1;
          next_q    = (SATURATE != 0) ? ALL_ONES : ZERO;
        end else begin
          next_q = q_r + ONE;
        end
      end
      FS_LOAD:   next_q = I;
      FS_CLR:    next_q = ZERO;
      FS_LOADLO: next_q = {{(WIDTH-HALF){1'b0}}, I[HALF-1:0]};
      FS_LOADHI: next_q = {I[WIDTH-1:HALF], q_r[HALF-1:0]};
      FS_SHL: begin
        next_q    = {q_r[WIDTH-2:0], 1'b0};
        next_wrap = q_r[WIDTH-1];
      end
      default:   next_q = q_r;  // FS_HOLD
    endcase
  end

  // Wrap is rewritten on every edge so it self-clears after one cycle,
  // including edges where this register is not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= ZERO;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= E & next_wrap;
      if (E) begin
        q_r <= next_q;
      end
    end
  end

  assign Q    = q_r;
  assign Wrap = wrap_r;

endmodule

// File: rtl/register_bank.sv
// register_bank
//   NREG independent WIDTH-bit registers sharing one operation bus, with two
//   combinational read ports.
//   Parameters: WIDTH (even, >= 4), NREG (power of two, >= 2),
//               SATURATE (0 = inc/dec wrap, 1 = clamp).
//   Ports:
//     clk  in   clock
//     rst  in   asynchronous active-high reset (clears registers and Wrap)
//     bus  register_bank_if.slave  (E, FunSel, I, OutASel, OutBSel in;
//                                   OutA, OutB, Wrap out)
//   Build option: define REGISTER_BANK_BYPASS_EN to forward I onto a read
//   port in the same cycle when the selected register is being loaded
//   (FunSel = FS_LOAD with its enable set). Without it, read ports show
//   stored contents only.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NREG     = 4,
  parameter int SATURATE = 0
) (
  input  logic           clk,
  input  logic           rst,
  register_bank_if.slave bus
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  wrap;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;

  for (genvar k = 0; k < NREG; k++) begin : g_cell
    register_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .E      (bus.E[k]),
      .FunSel (bus.FunSel),
      .I      (bus.I),
      .Q      (regs[k]),
      .Wrap   (wrap[k])
    );
  end

  always_comb begin
    out_a = regs[bus.OutASel];
    out_b = regs[bus.OutBSel];
`ifdef REGISTER_BANK_BYPASS_EN
    // Forwarding is suppressed during reset so the ports still read zero.
    if (!rst && bus.E[bus.OutASel] && (bus.FunSel == FS_LOAD)) begin
      out_a = bus.I;
    end
    if (!rst && bus.E[bus.OutBSel] && (bus.FunSel == FS_LOAD)) begin
      out_b = bus.I;
    end
`endif
  end

  assign bus.OutA = out_a;
  assign bus.OutB = out_b;
  assign bus.Wrap = wrap;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;
  import register_bank_pkg::*;

  localparam int WIDTH = 16;
  localparam int NREG  = 4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;

  // dut0: wrapping build, dut1: saturating build; dut1 mirrors dut0's inputs.
  register_bank_if #(.WIDTH(WIDTH), .NREG(NREG)) bus0 ();
  register_bank_if #(.WIDTH(WIDTH), .NREG(NREG)) bus1 ();

  assign bus1.E       = bus0.E;
  assign bus1.FunSel  = bus0.FunSel;
  assign bus1.I       = bus0.I;
  assign bus1.OutASel = bus0.OutASel;
  assign bus1.OutBSel = bus0.OutBSel;

  register_bank #(.WIDTH(WIDTH), .NREG(NREG), .SATURATE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  register_bank #(.WIDTH(WIDTH), .NREG(NREG), .SATURATE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read register idx on both ports of both builds.
  task automatic rd(input int idx, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1);
    bus0.OutASel = idx[1:0];
    bus0.OutBSel = idx[1:0];
    #1;
    chk($sformatf("r%0d_a_wrap", idx), bus0.OutA, e0);
    chk($sformatf("r%0d_b_wrap", idx), bus0.OutB, e0);
    chk($sformatf("r%0d_a_sat", idx),  bus1.OutA, e1);
    chk($sformatf("r%0d_b_sat", idx),  bus1.OutB, e1);
  endtask

  task automatic wchk(input string tag, input logic [NREG-1:0] e0, input logic [NREG-1:0] e1);
    chk({tag, "_wrap"}, {{(WIDTH-NREG){1'b0}}, bus0.Wrap}, {{(WIDTH-NREG){1'b0}}, e0});
    chk({tag, "_sat"},  {{(WIDTH-NREG){1'b0}}, bus1.Wrap}, {{(WIDTH-NREG){1'b0}}, e1});
  endtask

  // Apply one operation for exactly one edge, then park the bus idle.
  task automatic op(input logic [NREG-1:0] e, input logic [2:0] fs, input logic [WIDTH-1:0] data);
    bus0.E      = e;
    bus0.FunSel = fs;
    bus0.I      = data;
    @(posedge clk);
    #1;
    bus0.E      = '0;
    bus0.FunSel = FS_HOLD;
  endtask

  initial begin
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    rst          = 1'b1;
    bus0.E       = '0;
    bus0.FunSel  = FS_HOLD;
    bus0.I       = '0;
    bus0.OutASel = '0;
    bus0.OutBSel = '0;

    // reset state
    #2;
    wchk("reset", 4'b0000, 4'b0000);
    rd(0, 16'h0000, 16'h0000);
    rd(3, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // preload R0=ABCD R1=0000 R2=FFFF R3=8001
    op(4'b0001, FS_LOAD, 16'hABCD);
    op(4'b0010, FS_CLR,  16'h0000);
    op(4'b0100, FS_LOAD, 16'hFFFF);
    op(4'b1000, FS_LOAD, 16'h8001);
    rd(0, 16'hABCD, 16'hABCD);
    rd(1, 16'h0000, 16'h0000);
    rd(2, 16'hFFFF, 16'hFFFF);
    rd(3, 16'h8001, 16'h8001);

    // increment at all-ones: wrap vs clamp, flag for one cycle
    op(4'b0100, FS_INC, 16'h0000);
    wchk("inc_top", 4'b0100, 4'b0100);
    rd(2, 16'h0000, 16'hFFFF);
    op(4'b0000, FS_HOLD, 16'h0000);
    wchk("inc_top_after", 4'b0000, 4'b0000);

    // decrement at zero
    op(4'b0010, FS_DEC, 16'h0000);
    wchk("dec_bottom", 4'b0010, 4'b0010);
    rd(1, 16'hFFFF, 16'h0000);
    op(4'b0000, FS_HOLD, 16'h0000);
    wchk("dec_bottom_after", 4'b0000, 4'b0000);

    // half loads
    op(4'b0001, FS_LOADHI, 16'h1234);
    wchk("loadhi", 4'b0000, 4'b0000);
    rd(0, 16'h12CD, 16'h12CD);
    op(4'b0001, FS_LOADLO, 16'h1234);
    rd(0, 16'h0034, 16'h0034);

    // shift left: MSB out sets Wrap, then a zero shifts out
    op(4'b1000, FS_SHL, 16'h0000);
    wchk("shl_msb1", 4'b1000, 4'b1000);
    rd(3, 16'h0002, 16'h0002);
    op(4'b1000, FS_SHL, 16'h0000);
    wchk("shl_msb0", 4'b0000, 4'b0000);
    rd(3, 16'h0004, 16'h0004);

    // ordinary inc/dec
    op(4'b0001, FS_INC, 16'h0000);
    wchk("inc_mid", 4'b0000, 4'b0000);
    rd(0, 16'h0035, 16'h0035);
    op(4'b0001, FS_DEC, 16'h0000);
    rd(0, 16'h0034, 16'h0034);

    // no enable: clear must not take effect
    op(4'b0000, FS_CLR, 16'h0000);
    rd(0, 16'h0034, 16'h0034);

    // multi-register load, others untouched
    op(4'b1010, FS_LOAD, 16'h5A5A);
    rd(0, 16'h0034, 16'h0034);
    rd(1, 16'h5A5A, 16'h5A5A);
    rd(2, 16'h0000, 16'hFFFF);
    rd(3, 16'h5A5A, 16'h5A5A);

    // different registers on the two ports
    bus0.OutASel = 2'd0;
    bus0.OutBSel = 2'd3;
    #1;
    chk("split_a", bus0.OutA, 16'h0034);
    chk("split_b", bus0.OutB, 16'h5A5A);

    // read-during-write on R3
    @(posedge clk);
    #1;
    bus0.OutASel = 2'd3;
    bus0.OutBSel = 2'd2;
    bus0.E       = 4'b1000;
    bus0.FunSel  = FS_LOAD;
    bus0.I       = 16'h0F0F;
    #1;
`ifdef REGISTER_BANK_BYPASS_EN
    chk("rdw_before", bus0.OutA, 16'h0F0F);
`else
    chk("rdw_before", bus0.OutA, 16'h5A5A);
`endif
    chk("rdw_other_port", bus0.OutB, 16'h0000);
    @(posedge clk);
    #1;
    bus0.E      = '0;
    bus0.FunSel = FS_HOLD;
    #1;
    chk("rdw_after", bus0.OutA, 16'h0F0F);

    // explicit hold with every register enabled
    op(4'b1111, FS_HOLD, 16'hFFFF);
    wchk("hold_all", 4'b0000, 4'b0000);
    rd(0, 16'h0034, 16'h0034);
    rd(3, 16'h0F0F, 16'h0F0F);

    // reset mid-operation: E=1111 INC running, reset asserted between edges
    bus0.E      = 4'b1111;
    bus0.FunSel = FS_INC;
    @(posedge clk);
    #1;
    // dut0 R0..R3 = 0035 5A5B 0001 0F10; dut1 R2 clamps, Wrap=0100
    wchk("pre_reset", 4'b0000, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    wchk("async_reset", 4'b0000, 4'b0000);
    rd(0, 16'h0000, 16'h0000);
    rd(1, 16'h0000, 16'h0000);
    rd(2, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    rd(3, 16'h0000, 16'h0000);
    wchk("reset_held", 4'b0000, 4'b0000);
    rst = 1'b0;
    // first operation after reset release
    @(posedge clk);
    #1;
    bus0.E      = '0;
    bus0.FunSel = FS_HOLD;
    rd(0, 16'h0001, 16'h0001);
    rd(2, 16'h0001, 16'h0001);
    wchk("post_reset_inc", 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
